// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, FSM states
// and small op-decode helpers.
package muldiv_sequencer_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_sequencer_div_iter_core.sv
// Radix-2 restoring divider datapath on unsigned magnitudes. One step per
// enabled cycle; the step result is also exposed so the caller can capture
// the final quotient/remainder on the same edge as the last step.
module muldiv_sequencer_div_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step_en,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quot_step,
  output logic [WIDTH-1:0] rem_step
);

  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quot_r;
  logic [WIDTH-1:0] div_r;
  logic [WIDTH:0]   shifted_s;
  logic [WIDTH:0]   diff_s;

  // One restoring step: shift in the next dividend bit, subtract if it fits
  always_comb begin
    shifted_s = {rem_r, quot_r[WIDTH-1]};
    diff_s    = shifted_s - {1'b0, div_r};
    if (!diff_s[WIDTH]) begin
      rem_step  = diff_s[WIDTH-1:0];
      quot_step = {quot_r[WIDTH-2:0], 1'b1};
    end else begin
      rem_step  = shifted_s[WIDTH-1:0];
      quot_step = {quot_r[WIDTH-2:0], 1'b0};
    end
  end

  // Partial remainder / quotient shift registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_r  <= {WIDTH{1'b0}};
      quot_r <= {WIDTH{1'b0}};
      div_r  <= {WIDTH{1'b0}};
    end else if (load) begin
      rem_r  <= {WIDTH{1'b0}};
      quot_r <= dividend;
      div_r  <= divisor;
    end else if (step_en) begin
      rem_r  <= rem_step;
      quot_r <= quot_step;
    end else begin
      rem_r  <= rem_r;
      quot_r <= quot_r;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the execute stage: holds the
// pipeline via stall_o while an op runs and presents {hi,lo} in DONE.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] srca_i,
  input  logic [WIDTH-1:0] srcb_i,
  input  logic             cancel_i,
  input  logic             hold_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int DIV_ITER = WIDTH;
  localparam int CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_ITER - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic               mul_signed_r;
  logic               neg_q_r;
  logic               neg_r_r;
  logic               div_zero_r;
  logic               done_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  logic               accept_s;
  logic               step_s;
  logic               a_neg_s;
  logic               b_neg_s;
  logic [WIDTH-1:0]   a_mag_s;
  logic [WIDTH-1:0]   b_mag_s;
  logic [2*WIDTH-1:0] ext_a_s;
  logic [2*WIDTH-1:0] ext_b_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quot_step_s;
  logic [WIDTH-1:0]   rem_step_s;
  logic [WIDTH-1:0]   quot_fix_s;
  logic [WIDTH-1:0]   rem_fix_s;

  assign accept_s = (state_r == S_IDLE) && start_i && !cancel_i;
  assign step_s   = (state_r == S_DIV) && !cancel_i;
  assign stall_o  = accept_s || (((state_r == S_MUL) || (state_r == S_DIV)) && !cancel_i);
  assign busy_o   = (state_r != S_IDLE);
  assign done_o   = done_r;
  assign hi_o     = hi_r;
  assign lo_o     = lo_r;

  assign a_neg_s = op_is_signed(op_i) && srca_i[WIDTH-1];
  assign b_neg_s = op_is_signed(op_i) && srcb_i[WIDTH-1];
  assign a_mag_s = a_neg_s ? -srca_i : srca_i;
  assign b_mag_s = b_neg_s ? -srcb_i : srcb_i;

  // Sign/zero extension to 2*WIDTH makes one multiplier serve both MULT and MULTU
  assign ext_a_s = {{WIDTH{mul_signed_r & a_r[WIDTH-1]}}, a_r};
  assign ext_b_s = {{WIDTH{mul_signed_r & b_r[WIDTH-1]}}, b_r};
  assign prod_s  = ext_a_s * ext_b_s;

  assign quot_fix_s = neg_q_r ? -quot_step_s : quot_step_s;
  assign rem_fix_s  = neg_r_r ? -rem_step_s  : rem_step_s;

  muldiv_sequencer_div_iter_core #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .load      (accept_s),
    .step_en   (step_s),
    .dividend  (a_mag_s),
    .divisor   (b_mag_s),
    .quot_step (quot_step_s),
    .rem_step  (rem_step_s)
  );

  // Sequencer FSM: accept, multiply latency count, divide iterations, result hold
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      a_r          <= {WIDTH{1'b0}};
      b_r          <= {WIDTH{1'b0}};
      mul_signed_r <= 1'b0;
      neg_q_r      <= 1'b0;
      neg_r_r      <= 1'b0;
      div_zero_r   <= 1'b0;
      done_r       <= 1'b0;
      hi_r         <= {WIDTH{1'b0}};
      lo_r         <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          cnt_r <= {CNT_W{1'b0}};
          if (accept_s) begin
            a_r          <= srca_i;
            b_r          <= srcb_i;
            mul_signed_r <= op_is_signed(op_i);
            neg_q_r      <= a_neg_s ^ b_neg_s;
            neg_r_r      <= a_neg_s;
            div_zero_r   <= (srcb_i == {WIDTH{1'b0}});
            state_r      <= op_is_div(op_i) ? S_DIV : S_MUL;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_MUL: begin
          if (cancel_i) begin
            state_r <= S_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
          end else if (cnt_r == MUL_LAST) begin
            {hi_r, lo_r} <= prod_s;
            done_r       <= 1'b1;
            state_r      <= S_DONE;
            cnt_r        <= {CNT_W{1'b0}};
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        S_DIV: begin
          if (cancel_i) begin
            state_r <= S_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
          end else if (cnt_r == DIV_LAST) begin
            // Divide-by-zero reports all-ones quotient and the raw dividend
            if (div_zero_r) begin
              lo_r <= {WIDTH{1'b1}};
              hi_r <= a_r;
            end else begin
              lo_r <= quot_fix_s;
              hi_r <= rem_fix_s;
            end
            done_r  <= 1'b1;
            state_r <= S_DONE;
            cnt_r   <= {CNT_W{1'b0}};
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        S_DONE: begin
          if (cancel_i || !hold_i) begin
            state_r <= S_IDLE;
            done_r  <= 1'b0;
          end else begin
            state_r <= S_DONE;
          end
        end
        default: begin
          state_r <= S_IDLE;
          cnt_r   <= {CNT_W{1'b0}};
          done_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed vector table, corner
// sequences (cancel, hold, reset) and random ops against an arithmetic model.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  localparam int WIDTH   = 32;
  localparam int MUL_LAT = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start_i = 1'b0;
  logic [1:0]        op_i = 2'b00;
  logic [WIDTH-1:0]  srca_i = 32'h0;
  logic [WIDTH-1:0]  srcb_i = 32'h0;
  logic              cancel_i = 1'b0;
  logic              hold_i = 1'b0;
  logic              stall_o, busy_o, done_o;
  logic [WIDTH-1:0]  hi_o, lo_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] last_hi = 32'h0;
  logic [31:0] last_lo = 32'h0;

  muldiv_sequencer #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .srca_i(srca_i), .srcb_i(srcb_i), .cancel_i(cancel_i), .hold_i(hold_i),
    .stall_o(stall_o), .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          hold;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic, truncating division, explicit div-by-zero rule
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      MD_MULT: return sa * sb;
      MD_MULTU: begin
        u = {32'h0, a} * {32'h0, b};
        return u;
      end
      MD_DIV: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Issue one op from IDLE, count stalled cycles, check DONE, optional hold, return to IDLE
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold_n, input logic [31:0] eh, input logic [31:0] el,
                        input string name);
    int stalls;
    int exp_stalls;
    exp_stalls = op[1] ? WIDTH + 1 : MUL_LAT + 1;
    @(negedge clk);
    start_i = 1'b1; op_i = op; srca_i = a; srcb_i = b;
    #1;
    stalls = 0;
    while (stall_o && stalls < 200) begin
      stalls++;
      @(negedge clk);
      start_i = 1'b0; srca_i = $urandom; srcb_i = $urandom; op_i = 2'($urandom_range(0, 3));
      #1;
    end
    check({name, "/stall_cycles"}, 64'(stalls), 64'(exp_stalls));
    check({name, "/done"}, 64'(done_o), 64'd1);
    check({name, "/busy_in_done"}, 64'(busy_o), 64'd1);
    check({name, "/hilo"}, {hi_o, lo_o}, {eh, el});
    for (int i = 0; i < hold_n; i++) begin
      hold_i = 1'b1; start_i = 1'b1;
      @(negedge clk); #1;
      check({name, "/hold_done"}, 64'(done_o), 64'd1);
      check({name, "/hold_stall"}, 64'(stall_o), 64'd0);
      check({name, "/hold_hilo"}, {hi_o, lo_o}, {eh, el});
    end
    hold_i = 1'b0; start_i = 1'b0;
    @(negedge clk); #1;
    check({name, "/idle_done"}, 64'(done_o), 64'd0);
    check({name, "/idle_busy"}, 64'(busy_o), 64'd0);
    check({name, "/idle_hilo_kept"}, {hi_o, lo_o}, {eh, el});
    last_hi = eh; last_lo = el;
  endtask

  initial begin
    logic [63:0] exp;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    int          seen_done;

    vecs[0] = '{MD_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1] = '{MD_DIVU,  32'd100,       32'd7,         0, 32'd2,         32'd14};
    vecs[2] = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,         0, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0,         32'h8000_0000};
    vecs[4] = '{MD_DIVU,  32'd5,         32'd0,         0, 32'd5,         32'hFFFF_FFFF};
    vecs[5] = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[6] = '{MD_DIV,   32'd7,         32'hFFFF_FFFE, 0, 32'd1,         32'hFFFF_FFFD};
    vecs[7] = '{MD_DIV,   32'hFFFF_FFFB, 32'd0,         0, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vecs[8] = '{MD_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 32'h0,         32'h1};
    vecs[9] = '{MD_DIV,   32'hFFFF_FFF8, 32'hFFFF_FFFD, 0, 32'hFFFF_FFFE, 32'd2};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset/outputs", {29'h0, stall_o, busy_o, done_o, hi_o}, 64'h0);
    check("reset/lo", 64'(lo_o), 64'h0);
    rst = 1'b0;

    foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hold,
                             vecs[i].hi, vecs[i].lo, $sformatf("vec%0d", i));

    // start together with cancel in IDLE is not accepted
    @(negedge clk);
    start_i = 1'b1; cancel_i = 1'b1; op_i = MD_MULT; srca_i = 32'd9; srcb_i = 32'd9;
    #1;
    check("startcancel/stall", 64'(stall_o), 64'd0);
    @(negedge clk);
    start_i = 1'b0; cancel_i = 1'b0;
    #1;
    check("startcancel/busy", 64'(busy_o), 64'd0);

    // Cancel at DIV iteration 10
    start_i = 1'b1; op_i = MD_DIVU; srca_i = 32'd1000; srcb_i = 32'd3;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    cancel_i = 1'b1;
    #1;
    check("cancel/stall", 64'(stall_o), 64'd0);
    @(negedge clk);
    cancel_i = 1'b0;
    #1;
    check("cancel/busy", 64'(busy_o), 64'd0);
    check("cancel/hilo_kept", {hi_o, lo_o}, {last_hi, last_lo});
    seen_done = 0;
    repeat (40) begin
      @(negedge clk);
      seen_done += int'(done_o);
    end
    check("cancel/no_done", 64'(seen_done), 64'd0);
    run_op(MD_MULTU, 32'h1234_5678, 32'h0000_1000, 0, 32'h0000_0123, 32'h4567_8000, "after_cancel");

    // MULT then DIVU, reset asserted mid-divide
    run_op(MD_MULT, 32'd6, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "b2b_mult");
    start_i = 1'b1; op_i = MD_DIVU; srca_i = 32'd77; srcb_i = 32'd5;
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("midrst/ctrl", {61'h0, stall_o, busy_o, done_o}, 64'h0);
    check("midrst/hilo", {hi_o, lo_o}, 64'h0);
    rst = 1'b0;
    last_hi = 32'h0; last_lo = 32'h0;

    // Random ops against the model
    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if (i % 6 == 1) ra = {1'b1, ra[30:0]};
      exp = model(rop, ra, rb);
      run_op(rop, ra, rb, $urandom_range(0, 2), exp[63:32], exp[31:0], $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
